msi_tx_bfm: RTL and testbench

Testbench-side MSI transmitter for the endpoint application. It collects interrupt requests on up to INT_NUM vectors and arbitrates among them round-robin. Each winner becomes a single-DWord Memory Write TLP to the programmed MSI address, carrying MSI data with the vector number merged in. The TLP is issued on the core's client0 transmit interface, and this block is the counterpart of the MSI receive/detect logic on the root side.

---
 rtl/msi_tx_bfm_pkg.sv | 24 ++
 rtl/msi_tx_bfm_arb.sv | 34 +++
 rtl/msi_tx_bfm.sv | 146 ++++++++++++++
 tb/tb_msi_tx_bfm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_tx_bfm_pkg.sv
// Shared TLP format/type constants, FSM state type and MSI data-merge helper
// for the client0 MSI transmitter.
package msi_tx_bfm_pkg;

    localparam logic [4:0] MWR_TYPE     = 5'b00000;
    localparam logic [1:0] FMT_3DW_DATA = 2'b10;
    localparam logic [1:0] FMT_4DW_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } msi_state_e;

    // Low msi_mme bits of the message data carry the vector; higher vectors alias.
    function automatic logic [15:0] msi_merge_data(input logic [15:0] data,
                                                   input logic [2:0]  mme,
                                                   input logic [4:0]  vec);
        logic [15:0] mask;
        mask = ~(16'hFFFF << mme);
        return (data & ~mask) | ({11'd0, vec} & mask);
    endfunction

endpackage

// File: rtl/msi_tx_bfm_arb.sv
// Round-robin pending-vector selector: first pending vector at or after ptr,
// wrapping around INT_NUM.
module msi_vec_arb #(
    parameter int unsigned INT_NUM = 4
) (
    input  logic [INT_NUM-1:0] pend,
    input  logic [4:0]         ptr,
    output logic [4:0]         grant,
    output logic               any
);

    logic [2*INT_NUM-1:0] dbl;
    logic [INT_NUM-1:0]   rot;

    assign dbl = {pend, pend} >> ptr;
    assign rot = dbl[INT_NUM-1:0];

    always_comb begin : p_sel
        logic [5:0] idx;
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < INT_NUM; i++) begin
            idx = {1'b0, ptr} + 6'(i);
            if (idx >= 6'(INT_NUM))
                idx = idx - 6'(INT_NUM);
            if (!any && rot[i]) begin
                any   = 1'b1;
                grant = idx[4:0];
            end
        end
    end

endmodule

// File: rtl/msi_tx_bfm.sv
// Testbench-side MSI transmitter: collects vector requests, arbitrates
// round-robin and issues single-beat MWr TLPs on the client0 interface.
module msi_tx_bfm
    import msi_tx_bfm_pkg::*;
#(
    parameter int unsigned INT_NUM = 4,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic               core_clk,
    input  logic               core_rst_n,
    input  logic [INT_NUM-1:0] int_req,
    input  logic               msi_enable,
    input  logic [2:0]         msi_mme,
    input  logic [63:0]        msi_addr,
    input  logic [15:0]        msi_data,
    output logic               client0_tlp_hv,
    output logic               client0_tlp_dv,
    output logic               client0_tlp_eot,
    output logic [1:0]         client0_tlp_fmt,
    output logic [4:0]         client0_tlp_type,
    output logic [2:0]         client0_tlp_tc,
    output logic [2:0]         client0_tlp_attr,
    output logic [12:0]        client0_tlp_byte_len,
    output logic [63:0]        client0_tlp_addr,
    output logic [63:0]        client0_tlp_data,
    output logic [9:0]         client0_tlp_tid,
    input  logic               xadm_client0_halt,
    output logic [INT_NUM-1:0] int_pend,
    output logic               int_sent,
    output logic [4:0]         int_sent_vec
);

    localparam logic [3:0] GAP_LOAD = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);
    localparam logic [4:0] LAST_VEC = 5'(INT_NUM - 1);

    msi_state_e          state, state_nxt;
    logic                load, accept;
    logic [4:0]          rr_ptr;
    logic [4:0]          vec_q;
    logic [3:0]          gap_cnt;
    logic [4:0]          grant;
    logic                any_pend;
    logic [INT_NUM-1:0]  pend_clr;

    msi_vec_arb #(.INT_NUM(INT_NUM)) u_arb (
        .pend  (int_pend),
        .ptr   (rr_ptr),
        .grant (grant),
        .any   (any_pend)
    );

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (msi_enable && any_pend) begin
                    load      = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                // msi_enable is deliberately ignored: an issued TLP always completes
                if (!xadm_client0_halt) begin
                    accept    = 1'b1;
                    state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n)
            gap_cnt <= '0;
        else if (accept)
            gap_cnt <= GAP_LOAD;
        else if (state == ST_GAP && gap_cnt != 4'd0)
            gap_cnt <= gap_cnt - 4'd1;
    end

    // Set beats clear when a vector re-requests in its own acceptance cycle
    assign pend_clr = accept ? (INT_NUM'(1) << vec_q) : '0;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n)
            int_pend <= '0;
        else
            int_pend <= (int_pend & ~pend_clr) | int_req;
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            client0_tlp_hv   <= 1'b0;
            client0_tlp_dv   <= 1'b0;
            client0_tlp_eot  <= 1'b0;
            client0_tlp_fmt  <= '0;
            client0_tlp_type <= '0;
            client0_tlp_addr <= '0;
            client0_tlp_data <= '0;
            client0_tlp_tid  <= '0;
            vec_q            <= '0;
            rr_ptr           <= '0;
            int_sent         <= 1'b0;
            int_sent_vec     <= '0;
        end else begin
            int_sent <= 1'b0;
            if (load) begin
                client0_tlp_hv   <= 1'b1;
                client0_tlp_dv   <= 1'b1;
                client0_tlp_eot  <= 1'b1;
                client0_tlp_fmt  <= (|msi_addr[63:32]) ? FMT_4DW_DATA : FMT_3DW_DATA;
                client0_tlp_type <= MWR_TYPE;
                client0_tlp_addr <= {msi_addr[63:2], 2'b00};
                client0_tlp_data <= {48'd0, msi_merge_data(msi_data, msi_mme, grant)};
                vec_q            <= grant;
            end
            if (accept) begin
                client0_tlp_hv  <= 1'b0;
                client0_tlp_dv  <= 1'b0;
                client0_tlp_eot <= 1'b0;
                client0_tlp_tid <= client0_tlp_tid + 10'd1;
                int_sent        <= 1'b1;
                int_sent_vec    <= vec_q;
                rr_ptr          <= (vec_q == LAST_VEC) ? 5'd0 : vec_q + 5'd1;
            end
        end
    end

    assign client0_tlp_tc       = 3'd0;
    assign client0_tlp_attr     = 3'd0;
    assign client0_tlp_byte_len = 13'd4;

endmodule

// File: tb/tb_msi_tx_bfm.sv
// Scoreboard bench for msi_tx_bfm: stimulus pushes expected TLPs, a monitor
// pops and compares each accepted beat and the following int_sent pulse.
module tb_msi_tx_bfm;

    localparam int GAP = 2;

    typedef struct {
        logic [1:0]  fmt;
        logic [63:0] addr;
        logic [63:0] data;
        logic [9:0]  tid;
        logic [4:0]  vec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  int_req;
    logic        msi_enable;
    logic [2:0]  msi_mme;
    logic [63:0] msi_addr;
    logic [15:0] msi_data;
    logic        hv, dv, eot;
    logic [1:0]  fmt;
    logic [4:0]  ttype;
    logic [2:0]  tc, attr;
    logic [12:0] blen;
    logic [63:0] taddr, tdata;
    logic [9:0]  tid;
    logic        halt;
    logic [3:0]  int_pend;
    logic        int_sent;
    logic [4:0]  int_sent_vec;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_sent  = 0;
    exp_t q[$];
    int   acc_cyc[$];
    logic [9:0] exp_tid = '0;
    logic sent_due = 1'b0;
    logic [4:0] sent_vec_exp = '0;

    msi_tx_bfm #(.INT_NUM(4), .GAP_CYC(GAP)) dut (
        .core_clk             (clk),
        .core_rst_n           (rst_n),
        .int_req              (int_req),
        .msi_enable           (msi_enable),
        .msi_mme              (msi_mme),
        .msi_addr             (msi_addr),
        .msi_data             (msi_data),
        .client0_tlp_hv       (hv),
        .client0_tlp_dv       (dv),
        .client0_tlp_eot      (eot),
        .client0_tlp_fmt      (fmt),
        .client0_tlp_type     (ttype),
        .client0_tlp_tc       (tc),
        .client0_tlp_attr     (attr),
        .client0_tlp_byte_len (blen),
        .client0_tlp_addr     (taddr),
        .client0_tlp_data     (tdata),
        .client0_tlp_tid      (tid),
        .xadm_client0_halt    (halt),
        .int_pend             (int_pend),
        .int_sent             (int_sent),
        .int_sent_vec         (int_sent_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] f, input logic [63:0] a,
                            input logic [15:0] d, input logic [4:0] v);
        exp_t e;
        e.fmt  = f;
        e.addr = a;
        e.data = {48'd0, d};
        e.tid  = exp_tid;
        e.vec  = v;
        q.push_back(e);
        exp_tid = exp_tid + 10'd1;
    endtask

    // Monitor: every accepted beat must match the head of the queue
    always @(negedge clk) begin
        if (!rst_n) begin
            sent_due = 1'b0;
        end else begin
            if (int_sent) n_sent++;
            if (sent_due) begin
                chk("int_sent pulse", {63'd0, int_sent}, 64'd1);
                chk("int_sent_vec", {59'd0, int_sent_vec}, {59'd0, sent_vec_exp});
            end else if (int_sent) begin
                chk("spurious int_sent", {63'd0, int_sent}, 64'd0);
            end
            sent_due = 1'b0;
            if (hv && !halt) begin
                if (q.size() == 0) begin
                    chk("unexpected TLP", {63'd0, hv}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("hv/dv/eot", {61'd0, hv, dv, eot}, 64'd7);
                    chk("fmt", {62'd0, fmt}, {62'd0, e.fmt});
                    chk("type/tc/attr/len", {40'd0, ttype, tc, attr, blen}, {40'd0, 5'd0, 3'd0, 3'd0, 13'd4});
                    chk("addr", taddr, e.addr);
                    chk("data", tdata, e.data);
                    chk("tid", {54'd0, tid}, {54'd0, e.tid});
                    sent_vec_exp = e.vec;
                end
                sent_due = 1'b1;
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] v);
        @(posedge clk); #1 int_req = v;
        @(posedge clk); #1 int_req = '0;
    endtask

    task automatic wait_hv();
        int k = 0;
        while (!hv && k < 50) begin
            tick(1);
            k++;
        end
        chk("hv within bound", {63'd0, hv}, 64'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while ((q.size() != 0 || hv) && k < 300) begin
            tick(1);
            k++;
        end
        tick(GAP + 3);
        chk("scoreboard drained", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " valids"}, {61'd0, hv, dv, eot}, 64'd0);
        chk({tag, " fmt/type"}, {57'd0, fmt, ttype}, 64'd0);
        chk({tag, " addr"}, taddr, 64'd0);
        chk({tag, " data"}, tdata, 64'd0);
        chk({tag, " tid"}, {54'd0, tid}, 64'd0);
        chk({tag, " pend/sent"}, {54'd0, int_pend, int_sent, int_sent_vec}, 64'd0);
    endtask

    initial begin
        logic [63:0] s_addr, s_data, s_ctl;
        int k;
        rst_n = 1'b0; int_req = '0; msi_enable = 1'b1; msi_mme = 3'd2;
        msi_addr = 64'h0000_0000_FEE0_0000; msi_data = 16'h4020; halt = 1'b0;
        tick(3);
        chk_reset_outs("reset");
        rst_n = 1'b1;
        tick(2);

        // Single request with latency checks
        push_exp(2'b10, 64'hFEE0_0000, 16'h4022, 5'd2);
        pulse_req(4'b0100);
        chk("pend after req", {60'd0, int_pend}, 64'h4);
        chk("hv not yet", {63'd0, hv}, 64'd0);
        tick(1);
        chk("hv at N+2", {63'd0, hv}, 64'd1);
        wait_done();
        chk("pend cleared", {60'd0, int_pend}, 64'd0);

        // 4DW address, vector 3 aliases to 1 with mme=1
        msi_addr = 64'h0000_0001_0000_1000; msi_mme = 3'd1; msi_data = 16'hABCC;
        push_exp(2'b11, 64'h0000_0001_0000_1000, 16'hABCD, 5'd3);
        pulse_req(4'b1000);
        wait_done();

        // Round-robin 0,1,3 with GAP+2 spacing
        msi_addr = 64'h0000_0000_FEE0_0000; msi_mme = 3'd2; msi_data = 16'h4020;
        acc_cyc.delete();
        push_exp(2'b10, 64'hFEE0_0000, 16'h4020, 5'd0);
        push_exp(2'b10, 64'hFEE0_0000, 16'h4021, 5'd1);
        push_exp(2'b10, 64'hFEE0_0000, 16'h4023, 5'd3);
        pulse_req(4'b1011);
        wait_done();
        chk("rr count", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            chk("rr spacing 0-1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(GAP + 2));
            chk("rr spacing 1-3", 64'(acc_cyc[2] - acc_cyc[1]), 64'(GAP + 2));
        end
        chk("rr pend empty", {60'd0, int_pend}, 64'd0);

        // Halt for 5 SEND cycles, accepted on the 6th
        acc_cyc.delete();
        k = n_sent;
        halt = 1'b1;
        push_exp(2'b10, 64'hFEE0_0000, 16'h4020, 5'd0);
        pulse_req(4'b0001);
        wait_hv();
        s_addr = taddr; s_data = tdata;
        s_ctl = {39'd0, hv, dv, eot, fmt, ttype, tc, attr, tid};
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("halt hold ctl", {39'd0, hv, dv, eot, fmt, ttype, tc, attr, tid}, s_ctl);
            chk("halt hold addr", taddr, s_addr);
            chk("halt hold data", tdata, s_data);
        end
        halt = 1'b0;
        wait_done();
        chk("halt single sent", 64'(n_sent - k), 64'd1);

        // Gating: requests accumulate while disabled
        msi_enable = 1'b0;
        pulse_req(4'b0010);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("gated no hv", {63'd0, hv}, 64'd0);
        end
        chk("gated pend", {60'd0, int_pend}, 64'h2);
        push_exp(2'b10, 64'hFEE0_0000, 16'h4021, 5'd1);
        msi_enable = 1'b1;
        wait_hv();
        // Re-request in the acceptance cycle: set must win over clear
        push_exp(2'b10, 64'hFEE0_0000, 16'h4021, 5'd1);
        int_req = 4'b0010;
        tick(1);
        int_req = '0;
        chk("re-request pend", {60'd0, int_pend}, 64'h2);
        wait_done();
        chk("re-request pend drained", {60'd0, int_pend}, 64'd0);

        // Reset in SEND under halt
        halt = 1'b1;
        pulse_req(4'b0100);
        wait_hv();
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("mid-send reset");
        @(posedge clk); #1;
        rst_n = 1'b1; halt = 1'b0;
        exp_tid = '0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("no stale hv", {63'd0, hv}, 64'd0);
        end
        push_exp(2'b10, 64'hFEE0_0000, 16'h4023, 5'd3);
        pulse_req(4'b1000);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
